// File: rtl/cic_pkg.sv
// cic_pkg: shared width helpers and saturating resize for the CIC filters
package cic_pkg;

    function automatic int cic_l(input int r);
        return $clog2(r);
    endfunction

    function automatic int cic_w(input int bits_in, input int n, input int r);
        return bits_in + n * $clog2(r);
    endfunction

    function automatic int cic_s(input int n, input int r);
        return (n - 1) * $clog2(r);
    endfunction

    function automatic logic signed [63:0] sat_resize(input logic signed [63:0] v, input int bits);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (bits - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        return (v > hi) ? hi : ((v < lo) ? lo : v);
    endfunction

endpackage

// File: rtl/cic_integrator_chain.sv
// cic_integrator_chain: tick-enabled cascade of N wrapping integrators
module cic_integrator_chain #(
    parameter int N = 2,
    parameter int W = 38
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                tick_i,
    input  logic signed [W-1:0] u_i,
    output logic signed [W-1:0] sum_o
);

    logic signed [W-1:0] acc_q [N];
    logic signed [W-1:0] acc_d [N];
    logic signed [W-1:0] nxt [N];

    // each stage adds the pre-update value of its predecessor, keeping the chain registered
    always_comb begin
        nxt[0] = acc_q[0] + u_i;
        for (int j = 1; j < N; j++) nxt[j] = acc_q[j] + acc_q[j-1];
        for (int j = 0; j < N; j++) acc_d[j] = tick_i ? nxt[j] : acc_q[j];
        sum_o = nxt[N-1];
    end

    // accumulator state, cleared by reset
    always_ff @(posedge clk_i) begin
        if (reset_i) acc_q <= '{default: '0};
        else acc_q <= acc_d;
    end

endmodule

// File: rtl/cic_interpolator.sv
// cic_interpolator: comb / zero-stuff / integrator interpolation path with one-entry input holding register
module cic_interpolator
    import cic_pkg::*;
#(
    parameter int NUM_BITS_IN       = 24,
    parameter int NUM_BITS_OUT      = 24,
    parameter int CIC_STAGES        = 2,
    parameter int CIC_INTERPOLATION = 128
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic                           tick_i,
    input  logic signed [NUM_BITS_IN-1:0]  data_i,
    input  logic                           valid_i,
    output logic                           ready_o,
    output logic signed [NUM_BITS_OUT-1:0] data_o,
    output logic                           done_o,
    output logic                           underrun_o
);

    localparam int L = cic_l(CIC_INTERPOLATION);
    localparam int W = cic_w(NUM_BITS_IN, CIC_STAGES, CIC_INTERPOLATION);
    localparam int S = cic_s(CIC_STAGES, CIC_INTERPOLATION);

    if (CIC_INTERPOLATION < 2 || (CIC_INTERPOLATION & (CIC_INTERPOLATION - 1)) != 0) begin : g_bad_ratio
        $error("CIC_INTERPOLATION must be a power of two >= 2");
    end
    if (W > 64) begin : g_bad_width
        $error("internal CIC width exceeds 64 bits");
    end

    logic [L-1:0]                   phase_q, phase_d;
    logic                           full_q, full_d;
    logic signed [W-1:0]            hold_q, hold_d;
    logic signed [W-1:0]            z_q [CIC_STAGES];
    logic signed [W-1:0]            z_d [CIC_STAGES];
    logic signed [W-1:0]            d [CIC_STAGES+1];
    logic signed [NUM_BITS_OUT-1:0] data_q, data_d;
    logic                           done_q, done_d;
    logic                           underrun_q, underrun_d;
    logic                           pop, hs;
    logic signed [W-1:0]            u, sum, shifted;

    assign ready_o    = !full_q && !reset_i;
    assign data_o     = data_q;
    assign done_o     = done_q;
    assign underrun_o = underrun_q;

    // pop a sample at phase 0, run the comb chain on it and zero-stuff the other phases
    always_comb begin
        pop        = tick_i && (phase_q == '0);
        hs         = valid_i && ready_o;
        d[0]       = full_q ? hold_q : '0;
        for (int j = 1; j <= CIC_STAGES; j++) d[j] = d[j-1] - z_q[j-1];
        for (int j = 0; j < CIC_STAGES; j++) z_d[j] = pop ? d[j] : z_q[j];
        u          = pop ? d[CIC_STAGES] : '0;
        full_d     = hs ? 1'b1 : (pop ? 1'b0 : full_q);
        hold_d     = hs ? {{(W-NUM_BITS_IN){data_i[NUM_BITS_IN-1]}}, data_i} : hold_q;
        phase_d    = tick_i ? phase_q + 1'b1 : phase_q;
        shifted    = sum >>> S;
        data_d     = tick_i ? NUM_BITS_OUT'(sat_resize(64'(shifted), NUM_BITS_OUT)) : data_q;
        done_d     = tick_i;
        underrun_d = pop && !full_q;
    end

    cic_integrator_chain #(
        .N(CIC_STAGES),
        .W(W)
    ) u_integrators (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .tick_i (tick_i),
        .u_i    (u),
        .sum_o  (sum)
    );

    // holding register, phase, comb delays and output registers
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            phase_q    <= '0;
            full_q     <= 1'b0;
            hold_q     <= '0;
            z_q        <= '{default: '0};
            data_q     <= '0;
            done_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            phase_q    <= phase_d;
            full_q     <= full_d;
            hold_q     <= hold_d;
            z_q        <= z_d;
            data_q     <= data_d;
            done_q     <= done_d;
            underrun_q <= underrun_d;
        end
    end

endmodule

// File: tb/tb_cic_interpolator.sv
// tb_cic_interpolator: directed and random stimulus against a convolution reference model
module tb_cic_interpolator;

    localparam int R = 128;

    logic               clk_i = 1'b0;
    logic               reset_i = 1'b1;
    logic               tick_i = 1'b0;
    logic               valid_i = 1'b0;
    logic signed [23:0] data_i = '0;
    logic               ready_o, done_o, underrun_o;
    logic signed [23:0] data_o;
    logic               ready16, done16, und16;
    logic signed [15:0] data16;

    int     nchk = 0;
    int     fails = 0;
    longint pops[$];
    longint held = 0;
    bit     full_m = 0;
    longint t = 0;
    longint exp_y = 0;
    bit     exp_done = 0;
    bit     exp_und = 0;
    bit     exp_rst = 1;

    always #5 clk_i = ~clk_i;

    cic_interpolator dut (
        .clk_i(clk_i), .reset_i(reset_i), .tick_i(tick_i), .data_i(data_i), .valid_i(valid_i),
        .ready_o(ready_o), .data_o(data_o), .done_o(done_o), .underrun_o(underrun_o)
    );

    cic_interpolator #(.NUM_BITS_OUT(16)) dut16 (
        .clk_i(clk_i), .reset_i(reset_i), .tick_i(tick_i), .data_i(data_i), .valid_i(valid_i),
        .ready_o(ready16), .data_o(data16), .done_o(done16), .underrun_o(und16)
    );

    function automatic longint sat(input longint v, input int bits);
        longint hi;
        hi = (longint'(1) <<< (bits - 1)) - 1;
        return v > hi ? hi : (v < -hi - 1 ? -hi - 1 : v);
    endfunction

    // two-stage CIC interpolator response is a triangle of height R spanning 2R ticks, scaled by 1/R
    function automatic longint conv(input longint tt);
        longint y;
        longint k;
        int     n;
        y = 0;
        n = pops.size();
        for (int p = (n > 3 ? n - 3 : 0); p < n; p++) begin
            k = tt - longint'(p) * R;
            if (k >= 0 && k <= 2 * R) y += pops[p] * (k <= R ? k : 2 * R - k);
        end
        return y >>> 7;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        nchk++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(expv));
        end
    endtask

    task automatic cyc(input bit rst, input bit tk, input bit v, input longint d);
        bit pop;
        bit hs;
        reset_i = rst;
        tick_i  = tk;
        valid_i = v;
        data_i  = 24'(d);
        @(posedge clk_i);
        exp_rst = rst;
        if (rst) begin
            full_m = 0; pops.delete(); t = 0; exp_y = 0; exp_done = 0; exp_und = 0;
        end else begin
            pop = tk && (t % R == 0);
            hs = v && !full_m;
            exp_und = 0;
            if (pop) begin
                pops.push_back(full_m ? held : 0);
                exp_und = !full_m;
                full_m = 0;
            end
            if (hs) begin
                held = d;
                full_m = 1;
            end
            exp_done = tk;
            if (tk) begin
                exp_y = conv(t);
                t++;
            end
        end
        #1;
        chk("data24", 64'($signed(data_o)), 64'(sat(exp_y, 24)));
        chk("data16", 64'($signed(data16)), 64'(sat(exp_y, 16)));
        chk("done", 64'(done_o), 64'(exp_done));
        chk("done16", 64'(done16), 64'(exp_done));
        chk("underrun", 64'(underrun_o), 64'(exp_und));
        chk("underrun16", 64'(und16), 64'(exp_und));
        chk("ready", 64'(ready_o), 64'(!exp_rst && !full_m));
        chk("ready16", 64'(ready16), 64'(!exp_rst && !full_m));
    endtask

    initial begin
        logic signed [23:0] r;
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 0);
        // step: preload so the first pop finds a sample
        cyc(0, 0, 1, 12800);
        for (int i = 0; i < 300; i++) cyc(0, 1, 1, 12800);
        chk("step_final", 64'($signed(data_o)), 64'd12800);
        // reset mid-ramp at output 5000, then restart
        cyc(1, 0, 0, 0);
        cyc(0, 0, 1, 12800);
        for (int i = 0; i < 51; i++) cyc(0, 1, 1, 12800);
        chk("mid_ramp", 64'($signed(data_o)), 64'd5000);
        cyc(1, 1, 1, 12800);
        cyc(0, 0, 1, 12800);
        for (int i = 0; i < 20; i++) cyc(0, 1, 1, 12800);
        // impulse
        cyc(1, 0, 0, 0);
        cyc(0, 0, 1, 12800);
        cyc(0, 1, 1, 0);
        for (int i = 0; i < 300; i++) cyc(0, 1, 1, 0);
        // underrun with no input
        cyc(1, 0, 0, 0);
        for (int i = 0; i < 300; i++) cyc(0, 1, 0, 0);
        // handshake in the same cycle as a pop
        cyc(1, 0, 0, 0);
        cyc(0, 1, 1, 6400);
        for (int i = 0; i < 300; i++) cyc(0, 1, 0, 0);
        // saturation
        cyc(1, 0, 0, 0);
        cyc(0, 0, 1, 40000);
        for (int i = 0; i < 300; i++) cyc(0, 1, 1, 40000);
        chk("sat_hi", 64'($signed(data16)), 64'd32767);
        cyc(1, 0, 0, 0);
        cyc(0, 0, 1, -40000);
        for (int i = 0; i < 300; i++) cyc(0, 1, 1, -40000);
        chk("sat_lo", 64'($signed(data16)), -64'sd32768);
        // random ticks, valids and full-scale data
        cyc(1, 0, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            r = 24'($urandom);
            cyc(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), longint'(r));
        end
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, fails);
        $finish;
    end

endmodule
